// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU constants and the instruction-fetch FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 - the word shown to Decode whenever nothing valid is held
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  localparam logic [XLEN-1:0] RESET_PC_DFLT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  // Instruction addresses are word aligned; low two bits are dropped
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module      : instr_fetch_if
// Description : Bundles the instruction-memory handshake, the EX redirect and
//               the IF/ID hand-off of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_if;

  // Instruction memory request/response
  logic                     imem_req;
  logic [cpu_pkg::XLEN-1:0] imem_addr;
  logic                     imem_gnt;
  logic                     imem_rvalid;
  logic [cpu_pkg::XLEN-1:0] imem_rdata;

  // Redirect from EX
  logic                     redirect;
  logic [cpu_pkg::XLEN-1:0] redirect_pc;

  // IF/ID hand-off
  logic                     id_ready;
  logic                     if_valid;
  logic [cpu_pkg::XLEN-1:0] if_instr;
  logic [cpu_pkg::XLEN-1:0] if_pc;
  logic [cpu_pkg::XLEN-1:0] if_pc4;

  // Fetch stage side
  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

  // Memory / EX / Decode side
  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

endinterface

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
// Module      : fetch_skid_buf
// Description : Two-entry {instr,pc} buffer: a registered output stage plus a
//               skid entry that catches one word while Decode stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid_buf
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DFLT
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            flush_i,
  input  wire logic            in_valid_i,
  input  wire logic [XLEN-1:0] in_instr_i,
  input  wire logic [XLEN-1:0] in_pc_i,
  input  wire logic            out_ready_i,
  output logic                 out_valid_o,
  output logic [XLEN-1:0]      out_instr_o,
  output logic [XLEN-1:0]      out_pc_o,
  output logic                 skid_valid_o
);

  logic            out_valid_q,  out_valid_d;
  logic [XLEN-1:0] out_instr_q,  out_instr_d;
  logic [XLEN-1:0] out_pc_q,     out_pc_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
  logic            w_out_free;

  // The output stage can take a new word when empty or drained this cycle
  assign w_out_free = !out_valid_q || out_ready_i;

  // Next-state: flush wins, the skid entry has priority over a new word
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush_i) begin
      // Instruction/PC payload is kept so if_pc holds its last value
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (w_out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = in_valid_i;
        if (in_valid_i) begin
          skid_instr_d = in_instr_i;
          skid_pc_d    = in_pc_i;
        end
      end else begin
        out_valid_d = in_valid_i;
        if (in_valid_i) begin
          out_instr_d = in_instr_i;
          out_pc_d    = in_pc_i;
        end
      end
    end else if (in_valid_i) begin
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr_i;
      skid_pc_d    = in_pc_i;
    end
  end

  // Buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP_WORD;
      out_pc_q     <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_WORD;
      skid_pc_q    <= RESET_PC;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_instr_o  = out_instr_q;
  assign out_pc_o     = out_pc_q;
  assign skid_valid_o = skid_valid_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage - PC, single-outstanding imem request FSM,
//               redirect/kill handling; buffering lives in fetch_skid_buf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DFLT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input wire logic      clk,
  input wire logic      rst_n,
  instr_fetch_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] tag_pc_q, tag_pc_d;     // PC shadow of the outstanding word
  logic            outstanding_q, outstanding_d;
  logic            kill_q, kill_d;

  logic            w_req;
  logic            w_gnt_fire;
  logic            w_rsp_fire;
  logic            w_rsp_live;
  logic            w_space;
  logic            w_out_valid;
  logic [XLEN-1:0] w_out_instr;
  logic [XLEN-1:0] w_out_pc;
  logic            w_skid_valid;

  assign w_gnt_fire = (state_q == REQ) && bus.imem_gnt;
  // Responses only count while a request is actually in flight
  assign w_rsp_fire = outstanding_q && bus.imem_rvalid;
  // A redirect in the same cycle discards the arriving word as well
  assign w_rsp_live = w_rsp_fire && !kill_q && !bus.redirect;
  // Never issue a request whose response might have nowhere to land
  assign w_space    = !w_skid_valid && (!w_out_valid || bus.id_ready);

  fetch_skid_buf #(
    .RESET_PC (RESET_PC)
  ) u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (bus.redirect),
    .in_valid_i   (w_rsp_live),
    .in_instr_i   (bus.imem_rdata),
    .in_pc_i      (tag_pc_q),
    .out_ready_i  (bus.id_ready),
    .out_valid_o  (w_out_valid),
    .out_instr_o  (w_out_instr),
    .out_pc_o     (w_out_pc),
    .skid_valid_o (w_skid_valid)
  );

  // Fetch FSM next-state, request and redirect/kill bookkeeping
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    tag_pc_d      = tag_pc_q;
    outstanding_d = outstanding_q;
    kill_d        = kill_q;
    w_req         = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        w_req = 1'b1;
        if (bus.imem_gnt) begin
          outstanding_d = 1'b1;
          tag_pc_d      = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + 32'd4;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (w_rsp_fire) begin
          outstanding_d = 1'b0;
          kill_d        = 1'b0;
          state_d       = (w_space || bus.redirect) ? REQ : HOLD;
        end
      end
      HOLD: begin
        if (w_space || bus.redirect) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // Redirect overrides the sequential PC; an in-flight request is killed
    // unless its response is being dropped right now
    if (bus.redirect) begin
      fetch_pc_d = word_align(bus.redirect_pc);
      kill_d     = (outstanding_q && !bus.imem_rvalid) || w_gnt_fire;
    end
  end

  // Fetch FSM and PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      tag_pc_q      <= RESET_PC;
      outstanding_q <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      tag_pc_q      <= tag_pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.if_valid  = w_out_valid;
  assign bus.if_instr  = w_out_valid ? w_out_instr : NOP_INSTR;
  assign bus.if_pc     = w_out_pc;
  assign bus.if_pc4    = w_out_pc + 32'd4;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  int   n_checks = 0;
  int   n_fail   = 0;

  // Bench knobs written by the main sequence
  int   lat = 1;
  logic gnt_en = 1'b1;
  logic resp_clear = 1'b1;
  logic mon_clr = 1'b1;

  // Observed traffic
  logic [31:0] req_addr[$];
  int          req_cyc[$];
  logic [31:0] got_instr[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_pc4[$];
  int          got_cyc[$];

  instr_fetch_if bus();

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0000: memf = 32'h00003f37;
      32'h0000_0004: memf = 32'h02000fe7;
      32'h0000_0008: memf = 32'h042f0293;
      32'h0000_000C: memf = 32'h01f00333;
      32'h0000_0020: memf = 32'h00500193;
      32'h0000_0024: memf = 32'h00600213;
      32'hFFFF_FFFC: memf = 32'h00000073;
      default:       memf = {a[19:0], 12'h093};
    endcase
  endfunction

  // Memory responder: grants immediately, answers lat cycles later
  initial begin
    int          cnt;
    logic [31:0] paddr;
    cnt = 0;
    paddr = '0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0;
      if (resp_clear) begin
        cnt = 0;
      end else if (cnt != 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata = memf(paddr);
        end
      end else if (bus.imem_req && gnt_en) begin
        bus.imem_gnt = 1'b1;
        paddr = bus.imem_addr;
        cnt = lat;
      end
    end
  end

  // Monitor: record granted addresses and words taken by Decode
  always @(negedge clk) begin
    if (mon_clr) begin
      req_addr.delete();
      req_cyc.delete();
      got_instr.delete();
      got_pc.delete();
      got_pc4.delete();
      got_cyc.delete();
    end else begin
      if (bus.imem_req && bus.imem_gnt) begin
        req_addr.push_back(bus.imem_addr);
        req_cyc.push_back(cyc);
      end
      if (bus.if_valid && bus.id_ready && !bus.redirect) begin
        got_instr.push_back(bus.if_instr);
        got_pc.push_back(bus.if_pc);
        got_pc4.push_back(bus.if_pc4);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat_v, input logic gnt_en_v);
    rst_n = 1'b0;
    bus.redirect = 1'b0;
    bus.id_ready = 1'b1;
    gnt_en = gnt_en_v;
    lat = lat_v;
    mon_clr = 1'b1;
    resp_clear = 1'b1;
    tick();
    tick();
    mon_clr = 1'b0;
    resp_clear = 1'b0;
    rst_n = 1'b1;
  endtask

  // Wait (bounded) until the word at pc is displayed
  task automatic wait_shown(input string tag, input logic [31:0] pc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.if_valid && bus.if_pc == pc) found = 1'b1;
      else tick();
    end
    chk(tag, found, 1'b1);
  endtask

  // Wait (bounded) until n grants have been observed
  task automatic wait_reqs(input string tag, input int n);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (req_addr.size() >= n) found = 1'b1;
      else tick();
    end
    chk(tag, found, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready = 1'b1;

    // ---- reset values ----
    tick();
    chk("rst_req",   bus.imem_req,  32'd0);
    chk("rst_addr",  bus.imem_addr, 32'h0);
    chk("rst_valid", bus.if_valid,  32'd0);
    chk("rst_instr", bus.if_instr,  32'h00000013);
    chk("rst_pc",    bus.if_pc,     32'h0);
    chk("rst_pc4",   bus.if_pc4,    32'h4);

    // ---- A: straight-line fetch, 1-cycle memory ----
    do_reset(1, 1'b1);
    repeat (12) tick();
    chk("A_nreq",   req_addr.size() >= 3, 32'd1);
    chk("A_addr0",  req_addr[0], 32'h0);
    chk("A_addr1",  req_addr[1], 32'h4);
    chk("A_addr2",  req_addr[2], 32'h8);
    chk("A_nword",  got_instr.size() >= 2, 32'd1);
    chk("A_instr0", got_instr[0], 32'h00003f37);
    chk("A_pc0",    got_pc[0],    32'h0);
    chk("A_pc4_0",  got_pc4[0],   32'h4);
    chk("A_instr1", got_instr[1], 32'h02000fe7);
    chk("A_pc1",    got_pc[1],    32'h4);
    chk("A_lat",    got_cyc[0] - req_cyc[0], 32'd2);
    chk("A_rate",   got_cyc[1] - got_cyc[0], 32'd2);

    // ---- B: redirect while @8 is outstanding ----
    do_reset(2, 1'b1);
    wait_reqs("B_wait8", 3);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h23;
    tick();
    bus.redirect = 1'b0;
    repeat (12) tick();
    chk("B_addr2",  req_addr[2], 32'h8);
    chk("B_addr3",  req_addr[3], 32'h20);
    chk("B_pc1",    got_pc[1],    32'h4);
    chk("B_instr2", got_instr[2], 32'h00500193);
    chk("B_pc2",    got_pc[2],    32'h20);
    chk("B_pc4_2",  got_pc4[2],   32'h24);

    // ---- C: decode stall with out + skid full ----
    do_reset(1, 1'b1);
    wait_shown("C_wait8", 32'h8);
    bus.id_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      chk("C_hold_instr", bus.if_instr, 32'h042f0293);
      chk("C_hold_pc",    bus.if_pc,    32'h8);
      if (s >= 1) chk("C_hold_noreq", bus.imem_req, 32'd0);
      tick();
    end
    chk("C_nreq_stall", req_addr.size(), 32'd4);
    bus.id_ready = 1'b1;
    repeat (10) tick();
    chk("C_instr2", got_instr[2], 32'h042f0293);
    chk("C_instr3", got_instr[3], 32'h01f00333);
    chk("C_pc3",    got_pc[3],    32'hC);
    chk("C_b2b",    got_cyc[3] - got_cyc[2], 32'd1);

    // ---- D: redirect with both entries full and id_ready=1 ----
    do_reset(1, 1'b1);
    wait_shown("D_wait8", 32'h8);
    bus.id_ready = 1'b0;
    repeat (3) tick();
    chk("D_nreq_full", req_addr.size(), 32'd4);
    bus.id_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h24;
    tick();
    bus.redirect = 1'b0;
    chk("D_valid_after", bus.if_valid, 32'd0);
    chk("D_instr_after", bus.if_instr, 32'h00000013);
    repeat (10) tick();
    chk("D_addr4",  req_addr[4], 32'h24);
    chk("D_pc1",    got_pc[1],    32'h4);
    chk("D_instr2", got_instr[2], 32'h00600213);
    chk("D_pc2",    got_pc[2],    32'h24);

    // ---- E: redirect in REQ without grant, PC wrap ----
    do_reset(1, 1'b0);
    tick();
    chk("E_req",   bus.imem_req,  32'd1);
    chk("E_addr",  bus.imem_addr, 32'h0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFE;
    tick();
    bus.redirect = 1'b0;
    chk("E_addr_new", bus.imem_addr, 32'hFFFF_FFFC);
    chk("E_req_new",  bus.imem_req,  32'd1);
    gnt_en = 1'b1;
    repeat (10) tick();
    chk("E_addr0",  req_addr[0], 32'hFFFF_FFFC);
    chk("E_addr1",  req_addr[1], 32'h0);
    chk("E_instr0", got_instr[0], 32'h00000073);
    chk("E_pc0",    got_pc[0],    32'hFFFF_FFFC);
    chk("E_pc4_0",  got_pc4[0],   32'h0);
    chk("E_instr1", got_instr[1], 32'h00003f37);
    chk("E_pc1",    got_pc[1],    32'h0);

    // ---- F: reset in WAIT, stray rvalid afterwards ----
    do_reset(3, 1'b1);
    wait_reqs("F_wait_gnt", 1);
    rst_n = 1'b0;
    mon_clr = 1'b1;
    tick();
    chk("F_rst_req",   bus.imem_req,  32'd0);
    chk("F_rst_addr",  bus.imem_addr, 32'h0);
    chk("F_rst_valid", bus.if_valid,  32'd0);
    rst_n = 1'b1;
    mon_clr = 1'b0;
    tick();
    chk("F_stray_valid0", bus.if_valid, 32'd0);
    tick();
    chk("F_stray_valid1", bus.if_valid, 32'd0);
    repeat (10) tick();
    chk("F_addr0",  req_addr[0], 32'h0);
    chk("F_instr0", got_instr[0], 32'h00003f37);
    chk("F_pc0",    got_pc[0],    32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "time limit reached");
  end

endmodule

`default_nettype wire
